// File: rtl/pipelined_regfile_alu_datapath.sv
// Two-stage register-file + ALU datapath with S2->S1 forwarding and a side load port.
// Stage S1 holds the issued op and reads operands; S2 holds the registered ALU result
// and writes it back when it leaves the pipeline.
// Optional feature: define DATAPATH_MUL_EN to enable alu_ctrl 4'b1100 = MUL (low XLEN bits).
module pipelined_regfile_alu_datapath #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned NREGS         = 32,
  parameter bit          REGFILE_RESET = 1'b1,
  localparam int unsigned AW           = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic [3:0]      in_alu_ctrl,
  input  logic            in_wen,
  input  logic            ld_en,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_addr,
  input  logic [XLEN-1:0] ld_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [AW-1:0]   out_rd,
  output logic            out_zero
);

  localparam int unsigned SW = $clog2(XLEN);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
`ifdef DATAPATH_MUL_EN
  localparam logic [3:0] ALU_MUL  = 4'b1100;
`endif

  logic [XLEN-1:0] r_regs [NREGS];

  logic            r_s1_valid;
  logic [AW-1:0]   r_s1_rs1;
  logic [AW-1:0]   r_s1_rs2;
  logic [AW-1:0]   r_s1_rd;
  logic [3:0]      r_s1_ctrl;
  logic            r_s1_wen;

  logic            r_s2_valid;
  logic [XLEN-1:0] r_s2_result;
  logic [AW-1:0]   r_s2_rd;
  logic            r_s2_wen;

  logic            w_s2_adv;
  logic            w_issue;
  logic            w_wb;
  logic            w_ld_we;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [SW-1:0]   w_shamt;
  logic [XLEN-1:0] w_alu;

  // Handshake and write-enable decode
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign in_ready = !reset && !ld_en && (!r_s1_valid || w_s2_adv);
  assign w_issue  = in_valid && in_ready;
  assign w_wb     = r_s2_valid && out_ready && r_s2_wen && (r_s2_rd != '0);
  assign ld_ready = !reset && !w_wb;
  assign w_ld_we  = ld_en && ld_ready && (ld_addr != '0);

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_rd     = r_s2_rd;
  assign out_zero   = (r_s2_result == '0);

  // Operand read: x0 is hard zero, S2 result forwarded over a stale regfile entry
  always_comb begin
    w_a = '0;
    w_b = '0;
    if (r_s1_rs1 != '0) begin
      if (r_s2_valid && r_s2_wen && (r_s2_rd == r_s1_rs1)) w_a = r_s2_result;
      else                                                  w_a = r_regs[r_s1_rs1];
    end
    if (r_s1_rs2 != '0) begin
      if (r_s2_valid && r_s2_wen && (r_s2_rd == r_s1_rs2)) w_b = r_s2_result;
      else                                                  w_b = r_regs[r_s1_rs2];
    end
  end

  assign w_shamt = w_b[SW-1:0];

  // ALU: wrap-around arithmetic, unused codes yield zero
  always_comb begin
    w_alu = '0;
    case (r_s1_ctrl)
      ALU_AND:  w_alu = w_a & w_b;
      ALU_OR:   w_alu = w_a | w_b;
      ALU_ADD:  w_alu = w_a + w_b;
      ALU_XOR:  w_alu = w_a ^ w_b;
      ALU_SUB:  w_alu = w_a - w_b;
      ALU_SLT:  w_alu = XLEN'($signed(w_a) < $signed(w_b));
      ALU_SLTU: w_alu = XLEN'(w_a < w_b);
      ALU_SLL:  w_alu = w_a << w_shamt;
      ALU_SRL:  w_alu = w_a >> w_shamt;
      ALU_SRA:  w_alu = XLEN'($signed(w_a) >>> w_shamt);
`ifdef DATAPATH_MUL_EN
      ALU_MUL:  w_alu = w_a * w_b;
`else
`endif
      default:  w_alu = '0;
    endcase
  end

  // Register file: writeback has priority; loads are never granted in a writeback cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      if (REGFILE_RESET) begin
        for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
      end
    end else if (w_wb) begin
      r_regs[r_s2_rd] <= r_s2_result;
    end else if (w_ld_we) begin
      r_regs[ld_addr] <= ld_data;
    end
  end

  // Stage S1: captures the accepted op, empties when it moves on with nothing behind it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_rs1   <= '0;
      r_s1_rs2   <= '0;
      r_s1_rd    <= '0;
      r_s1_ctrl  <= '0;
      r_s1_wen   <= 1'b0;
    end else if (w_issue) begin
      r_s1_valid <= 1'b1;
      r_s1_rs1   <= in_rs1;
      r_s1_rs2   <= in_rs2;
      r_s1_rd    <= in_rd;
      r_s1_ctrl  <= in_alu_ctrl;
      r_s1_wen   <= in_wen;
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage S2: registered result, held stable under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_rd     <= '0;
      r_s2_wen    <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result <= w_alu;
        r_s2_rd     <= r_s1_rd;
        r_s2_wen    <= r_s1_wen;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_regfile_alu_datapath.sv
// Scoreboard bench for pipelined_regfile_alu_datapath (XLEN=32, NREGS=32, registers cleared on reset).
module tb_pipelined_regfile_alu_datapath;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [3:0]  in_alu_ctrl;
  logic        in_wen;
  logic        ld_en;
  logic        ld_ready;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_zero;

  int          n_vec = 0;
  int          n_err = 0;
  int          bp_mode = 0;
  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] model [32];

  pipelined_regfile_alu_datapath #(.XLEN(32), .NREGS(32), .REGFILE_RESET(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_alu_ctrl(in_alu_ctrl), .in_wen(in_wen),
    .ld_en(ld_en), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  // Reference ALU straight from the operation table
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (c)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd6:  return a - b;
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd11: return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return a << sh;
      4'd9:  return a >> sh;
      4'd10: return 32'($signed(a) >>> sh);
`ifdef DATAPATH_MUL_EN
      4'd12: return 32'(a * b);
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Backpressure driver: 0 always ready, 1 stalled, 2 random
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: every transferred result is checked against the oldest expectation
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got result %h rd %0d expected none", out_result, out_rd);
      end else begin
        mon_e = q.pop_front();
        check("mon_result", out_result, mon_e.res);
        check("mon_rd", 32'(out_rd), 32'(mon_e.rd));
        check("mon_zero", 32'(out_zero), 32'(mon_e.res == 32'd0));
      end
    end
  end

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [3:0] c, input logic w);
    bit   acc = 1'b0;
    exp_t e;
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_alu_ctrl = c; in_wen = w;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc   = 1'b1;
        e.res = ref_alu(c, model[rs1], model[rs2]);
        e.rd  = rd;
        if (w && rd != 5'd0) model[rd] = e.res;
        q.push_back(e);
      end
      @(posedge clk); #1;
    end
    if (!acc) check("issue_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic ld(input logic [4:0] a, input logic [31:0] d);
    bit acc = 1'b0;
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (ld_ready) begin
        acc = 1'b1;
        check("ld_blocks_issue", 32'(in_ready), 32'd0);
        if (a != 5'd0) model[a] = d;
      end
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
    if (!acc) check("ld_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_out(input string name, input logic [31:0] exp);
    bit got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = 1'b1;
        check(name, out_result, exp);
        check({name, "_zero"}, 32'(out_zero), 32'(exp == 32'd0));
      end
      @(posedge clk); #1;
    end
    if (!got) check({name, "_timeout"}, 32'(got), 32'd1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      done = (q.size() == 0) && !out_valid;
      @(posedge clk); #1;
    end
    if (!done) check("drain_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    reset = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_alu_ctrl = '0; in_wen = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    // Reset state over two cycles
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Loads then ADD with latency check
    ld(5'd5, 32'd10);
    ld(5'd20, 32'd2);
    issue(5'd5, 5'd20, 5'd4, 4'd2, 1'b1);
    idle();
    @(negedge clk);
    check("latency_s1_not_out", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    wait_out("add_x4", 32'd12);
    issue(5'd4, 5'd0, 5'd0, 4'd1, 1'b0);
    idle();
    wait_out("read_x4", 32'd12);

    // Back-to-back dependent ops rely on forwarding
    issue(5'd5, 5'd20, 5'd6, 4'd2, 1'b1);
    issue(5'd6, 5'd20, 5'd7, 4'd6, 1'b1);
    idle();
    wait_out("fwd_add_x6", 32'd12);
    wait_out("fwd_sub_x7", 32'd10);

    // Full backpressure with two ops in flight
    bp_mode = 1;
    issue(5'd5, 5'd5, 5'd8, 4'd2, 1'b1);
    issue(5'd8, 5'd20, 5'd9, 4'd3, 1'b1);
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_result", out_result, 32'd20);
      check("stall_out_rd", 32'(out_rd), 32'd8);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bp_mode = 0;
    wait_out("drain_x8", 32'd20);
    wait_out("drain_x9", 32'd22);
    issue(5'd9, 5'd0, 5'd0, 4'd1, 1'b0);
    idle();
    wait_out("read_x9", 32'd22);

    // x0 stays zero whatever writes to it
    issue(5'd5, 5'd5, 5'd0, 4'd6, 1'b1);
    idle();
    wait_out("sub_rd0", 32'd0);
    ld(5'd0, 32'hDEAD_BEEF);
    issue(5'd0, 5'd0, 5'd0, 4'd1, 1'b0);
    idle();
    wait_out("read_x0", 32'd0);

    // Reset with ops in S1 and S2
    bp_mode = 1;
    issue(5'd5, 5'd20, 5'd10, 4'd2, 1'b1);
    issue(5'd5, 5'd5, 5'd11, 4'd2, 1'b1);
    idle();
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_ld_ready", 32'(ld_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_zero", 32'(out_zero), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    bp_mode = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    @(negedge clk);
    check("mid_post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    issue(5'd5, 5'd0, 5'd0, 4'd1, 1'b0);
    issue(5'd10, 5'd0, 5'd0, 4'd1, 1'b0);
    idle();
    wait_out("rst_cleared_x5", 32'd0);
    wait_out("rst_cleared_x10", 32'd0);

    // Randomised traffic with random backpressure and interleaved loads
    bp_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if (i % 60 == 0) begin
        idle();
        drain();
        for (int j = 0; j < 3; j++) begin
          case ($urandom_range(0, 2))
            0:       ld(5'($urandom_range(0, 7)), $urandom);
            1:       ld(5'($urandom_range(0, 7)), 32'($urandom_range(0, 40)));
            default: ld(5'($urandom_range(0, 7)), 32'hFFFF_FF00 | 32'($urandom_range(0, 255)));
          endcase
        end
      end
      if ($urandom_range(0, 4) == 0) begin
        idle();
        @(posedge clk); #1;
      end else begin
        issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
    end
    idle();
    drain();
    bp_mode = 0;
    for (int r = 0; r < 8; r++) issue(5'(r), 5'd0, 5'd0, 4'd1, 1'b0);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
